// File: rtl/jogo_desafio_memoria.sv
// Memory-challenge game: FSM, counters, 16x4 play RAM, press edge detector and 7-seg debug outputs.
// Latency: a press reaches the compare state two clocks after its rising edge; outputs are Moore except leds/db_tem_jogada.
// Backpressure: none; presses outside the wait states only update the play register, and a held press counts once.
// Ports: clock/reset (async, active-low), iniciar start request, botoes one-hot buttons;
//        ganhou/perdeu/pronto game result, leds, 7-seg debug digits (gfedcba, active-low), raw debug flags, db_Q timer.
module jogo_desafio_memoria #(
    parameter int T_MOSTRA  = 2000,
    parameter int T_TIMEOUT = 5000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        iniciar,
    input  logic [3:0]  botoes,
    output logic        ganhou,
    output logic        perdeu,
    output logic        pronto,
    output logic [3:0]  leds,
    output logic [6:0]  db_contagem,
    output logic [6:0]  db_memoria,
    output logic [6:0]  db_estado,
    output logic [6:0]  db_jogadafeita,
    output logic [6:0]  db_rodada,
    output logic        db_clock,
    output logic        db_tem_jogada,
    output logic        db_timeout,
    output logic        db_jogada_correta,
    output logic        db_enderecoIgualRodada,
    output logic        db_grava,
    output logic [12:0] db_Q
);

    localparam int MW = $clog2(T_MOSTRA + 1);

    typedef enum logic [3:0] {
        INICIAL      = 4'h0,
        PREPARA      = 4'h1,
        MOSTRA       = 4'h2,
        ESPERA       = 4'h3,
        REGISTRA     = 4'h4,
        COMPARA      = 4'h5,
        PROXIMO      = 4'h6,
        ESPERA_ESC   = 4'h7,
        REGISTRA_ESC = 4'h8,
        GRAVA        = 4'h9,
        PROX_RODADA  = 4'hA,
        GANHOU       = 4'hB,
        PERDEU       = 4'hE,
        PERDEU_TO    = 4'hF
    } estado_t;

    estado_t        estado_q, estado_d;
    logic [3:0]     botoes_q, botoes_d;
    logic [3:0]     jogada_q, jogada_d;
    logic [3:0]     endereco_q, endereco_d;
    logic [3:0]     rodada_q, rodada_d;
    logic [MW-1:0]  mostra_q, mostra_d;
    logic [12:0]    tempo_q, tempo_d;
    logic [3:0]     mem_q [16];
    logic [3:0]     mem_d [16];

    logic           tem_jogada;
    logic [3:0]     dado_mem;
    logic           jogada_correta;
    logic           endereco_igual;
    logic           tempo_esgotado;
    logic           grava;
    logic           ganhou_c, perdeu_c, pronto_c, timeout_c;
    logic [3:0]     leds_c;

    function automatic logic [6:0] hex7seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // A play is the first cycle in which any button is down after all were released.
    assign tem_jogada     = (|botoes) & ~(|botoes_q);
    assign dado_mem       = mem_q[endereco_q];
    assign jogada_correta = (jogada_q == dado_mem);
    assign endereco_igual = (endereco_q == rodada_q);
    assign tempo_esgotado = (tempo_q == 13'(T_TIMEOUT - 1));

    always_comb begin
        estado_d   = estado_q;
        botoes_d   = botoes;
        jogada_d   = tem_jogada ? botoes : jogada_q;
        endereco_d = endereco_q;
        rodada_d   = rodada_q;
        mostra_d   = '0;
        tempo_d    = '0;   // timer only survives while waiting for a play
        mem_d      = mem_q;
        grava      = 1'b0;
        ganhou_c   = 1'b0;
        perdeu_c   = 1'b0;
        pronto_c   = 1'b0;
        timeout_c  = 1'b0;
        leds_c     = 4'b0000;

        case (estado_q)
            INICIAL: begin
                if (iniciar) estado_d = PREPARA;
            end
            PREPARA: begin
                endereco_d = 4'd0;
                rodada_d   = 4'd0;
                estado_d   = MOSTRA;
            end
            MOSTRA: begin
                leds_c = mem_q[0];
                if (mostra_q == MW'(T_MOSTRA - 1)) estado_d = ESPERA;
                else                               mostra_d = mostra_q + 1'b1;
            end
            ESPERA: begin
                leds_c = botoes;
                if (tem_jogada)          estado_d = REGISTRA;
                else if (tempo_esgotado) estado_d = PERDEU_TO;
                else                     tempo_d  = tempo_q + 13'd1;
            end
            REGISTRA: estado_d = COMPARA;
            COMPARA: begin
                if (!jogada_correta) begin
                    estado_d = PERDEU;
                end else if (endereco_igual) begin
                    if (rodada_q == 4'd15) begin
                        estado_d = GANHOU;
                    end else begin
                        // the new play goes one slot past the last repeated one
                        endereco_d = endereco_q + 4'd1;
                        estado_d   = ESPERA_ESC;
                    end
                end else begin
                    estado_d = PROXIMO;
                end
            end
            PROXIMO: begin
                endereco_d = endereco_q + 4'd1;
                estado_d   = ESPERA;
            end
            ESPERA_ESC: begin
                leds_c = botoes;
                if (tem_jogada)          estado_d = REGISTRA_ESC;
                else if (tempo_esgotado) estado_d = PERDEU_TO;
                else                     tempo_d  = tempo_q + 13'd1;
            end
            REGISTRA_ESC: estado_d = GRAVA;
            GRAVA: begin
                grava               = 1'b1;
                mem_d[endereco_q]   = jogada_q;
                estado_d            = PROX_RODADA;
            end
            PROX_RODADA: begin
                rodada_d   = rodada_q + 4'd1;
                endereco_d = 4'd0;
                estado_d   = ESPERA;
            end
            GANHOU: begin
                ganhou_c = 1'b1;
                pronto_c = 1'b1;
                if (iniciar) estado_d = PREPARA;
            end
            PERDEU: begin
                perdeu_c = 1'b1;
                pronto_c = 1'b1;
                if (iniciar) estado_d = PREPARA;
            end
            PERDEU_TO: begin
                perdeu_c  = 1'b1;
                pronto_c  = 1'b1;
                timeout_c = 1'b1;
                if (iniciar) estado_d = PREPARA;
            end
            default: estado_d = INICIAL;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q   <= INICIAL;
            botoes_q   <= 4'b0000;
            jogada_q   <= 4'b0000;
            endereco_q <= 4'd0;
            rodada_q   <= 4'd0;
            mostra_q   <= '0;
            tempo_q    <= '0;
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= (i == 0) ? 4'b0001 : 4'b0000;
            end
        end else begin
            estado_q   <= estado_d;
            botoes_q   <= botoes_d;
            jogada_q   <= jogada_d;
            endereco_q <= endereco_d;
            rodada_q   <= rodada_d;
            mostra_q   <= mostra_d;
            tempo_q    <= tempo_d;
            mem_q      <= mem_d;
        end
    end

    assign ganhou         = ganhou_c;
    assign perdeu         = perdeu_c;
    assign pronto         = pronto_c;
    assign leds           = leds_c;
    assign db_contagem    = hex7seg(endereco_q);
    assign db_memoria     = hex7seg(dado_mem);
    assign db_estado      = hex7seg(estado_q);
    assign db_jogadafeita = hex7seg(jogada_q);
    assign db_rodada      = hex7seg(rodada_q);
    assign db_clock       = clock;
    assign db_tem_jogada  = tem_jogada;
    assign db_timeout     = timeout_c;
    assign db_grava       = grava;
    assign db_Q           = tempo_q;
    // Compare flags are held low while idle so that reset leaves every flag low.
    assign db_jogada_correta      = (estado_q != INICIAL) && jogada_correta;
    assign db_enderecoIgualRodada = (estado_q != INICIAL) && endereco_igual;

endmodule

// File: tb/tb_jogo_desafio_memoria.sv
module tb_jogo_desafio_memoria;

    localparam int T_MOSTRA  = 2000;
    localparam int T_TIMEOUT = 5000;
    localparam int T_ON      = 30;
    localparam int T_OFF     = 30;

    logic        clock;
    logic        reset;
    logic        iniciar;
    logic [3:0]  botoes;
    logic        ganhou, perdeu, pronto;
    logic [3:0]  leds;
    logic [6:0]  db_contagem, db_memoria, db_estado, db_jogadafeita, db_rodada;
    logic        db_clock, db_tem_jogada, db_timeout, db_jogada_correta;
    logic        db_enderecoIgualRodada, db_grava;
    logic [12:0] db_Q;

    jogo_desafio_memoria #(.T_MOSTRA(T_MOSTRA), .T_TIMEOUT(T_TIMEOUT)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .botoes(botoes),
        .ganhou(ganhou), .perdeu(perdeu), .pronto(pronto), .leds(leds),
        .db_contagem(db_contagem), .db_memoria(db_memoria), .db_estado(db_estado),
        .db_jogadafeita(db_jogadafeita), .db_rodada(db_rodada), .db_clock(db_clock),
        .db_tem_jogada(db_tem_jogada), .db_timeout(db_timeout),
        .db_jogada_correta(db_jogada_correta),
        .db_enderecoIgualRodada(db_enderecoIgualRodada),
        .db_grava(db_grava), .db_Q(db_Q)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       g;
        logic       p;
        logic       t;
        logic [6:0] e;
    } fim_t;

    bit   exp_cmp[$];
    fim_t exp_fim[$];
    logic pronto_ant = 1'b0;

    // standard active-low gfedcba digits
    function automatic logic [6:0] seg(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h5: return 7'h12;
            4'h7: return 7'h78;
            4'hB: return 7'h03;
            4'hE: return 7'h06;
            4'hF: return 7'h0E;
            default: return 7'h7F;
        endcase
    endfunction

    // the game's colour sequence: 1,2,4,8,4,2 repeating
    function automatic logic [3:0] seq_at(input int i);
        case (i % 6)
            0: return 4'b0001;
            1: return 4'b0010;
            2: return 4'b0100;
            3: return 4'b1000;
            4: return 4'b0100;
            default: return 4'b0010;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_fim(input logic g, input logic p, input logic t, input logic [3:0] code);
        fim_t f;
        f.g = g;
        f.p = p;
        f.t = t;
        f.e = seg(code);
        exp_fim.push_back(f);
    endtask

    // Monitor: checks every compare cycle and every game end against the queued expectations.
    initial begin
        bit   b;
        fim_t f;
        forever begin
            @(negedge clock);
            if (reset && db_estado == seg(4'h5)) begin
                if (exp_cmp.size() == 0) chk("cmp_unexpected", exp_cmp.size(), 1);
                else begin
                    b = exp_cmp.pop_front();
                    chk("jogada_correta", int'(db_jogada_correta), int'(b));
                end
            end
            if (reset && pronto && !pronto_ant) begin
                if (exp_fim.size() == 0) chk("end_unexpected", exp_fim.size(), 1);
                else begin
                    f = exp_fim.pop_front();
                    chk("end_ganhou",     int'(ganhou),     int'(f.g));
                    chk("end_perdeu",     int'(perdeu),     int'(f.p));
                    chk("end_db_timeout", int'(db_timeout), int'(f.t));
                    chk("end_estado",     int'(db_estado),  int'(f.e));
                end
            end
            pronto_ant = pronto;
        end
    end

    task automatic press(input logic [3:0] v);
        botoes = v;
        repeat (T_ON) @(negedge clock);
        botoes = 4'b0000;
        repeat (T_OFF) @(negedge clock);
    endtask

    task automatic start_game();
        int n;
        iniciar = 1'b1;
        @(negedge clock);
        chk("estado_prepara", int'(db_estado), int'(seg(4'h1)));
        @(negedge clock);
        chk("estado_mostra", int'(db_estado), int'(seg(4'h2)));
        chk("leds_mostra",   int'(leds), 1);
        chk("start_ganhou",  int'(ganhou), 0);
        chk("start_perdeu",  int'(perdeu), 0);
        chk("start_pronto",  int'(pronto), 0);
        chk("start_timeout", int'(db_timeout), 0);
        n = 1;
        while (n < T_MOSTRA + 500) begin
            @(negedge clock);
            if (n == 4) iniciar = 1'b0;
            if (db_estado != seg(4'h2)) break;
            n++;
        end
        iniciar = 1'b0;
        chk("mostra_cycles", n, T_MOSTRA);
        chk("estado_espera", int'(db_estado), int'(seg(4'h3)));
    endtask

    task automatic play_game(input bit erra);
        for (int r = 0; r < 16; r++) begin
            for (int a = 0; a <= r; a++) begin
                if (erra && r == 15 && a == 15) begin
                    exp_cmp.push_back(1'b0);
                    press(4'b0001);
                end else begin
                    exp_cmp.push_back(1'b1);
                    press(seq_at(a));
                end
            end
            if (r < 15) press(seq_at(r + 1));
        end
    endtask

    task automatic wait_pronto(input int budget);
        int n;
        n = 0;
        while (!pronto && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (!pronto) chk("wait_pronto", 0, 1);
    endtask

    initial begin
        #(1_000_000);
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int n;
        reset   = 1'b0;
        iniciar = 1'b0;
        botoes  = 4'b0000;
        repeat (3) @(negedge clock);
        chk("rst_estado",  int'(db_estado), int'(seg(4'h0)));
        chk("rst_ganhou",  int'(ganhou), 0);
        chk("rst_perdeu",  int'(perdeu), 0);
        chk("rst_pronto",  int'(pronto), 0);
        chk("rst_leds",    int'(leds), 0);
        chk("rst_timeout", int'(db_timeout), 0);
        chk("rst_grava",   int'(db_grava), 0);
        chk("rst_tem",     int'(db_tem_jogada), 0);
        chk("rst_correta", int'(db_jogada_correta), 0);
        chk("rst_igual",   int'(db_enderecoIgualRodada), 0);
        chk("rst_Q",       int'(db_Q), 0);
        chk("rst_memoria", int'(db_memoria), int'(seg(4'h1)));
        reset = 1'b1;
        @(negedge clock);
        chk("idle_estado", int'(db_estado), int'(seg(4'h0)));

        // full winning game
        push_fim(1'b1, 1'b0, 1'b0, 4'hB);
        start_game();
        play_game(1'b0);
        wait_pronto(200);

        // restart, wrong colour at address 15 of round 15
        push_fim(1'b0, 1'b1, 1'b0, 4'hE);
        start_game();
        play_game(1'b1);
        wait_pronto(200);

        // restart, never press: timeout out of the first wait
        push_fim(1'b0, 1'b1, 1'b1, 4'hF);
        start_game();
        n = 1;
        while (n < T_TIMEOUT + 500) begin
            @(negedge clock);
            if (db_estado != seg(4'h3)) break;
            n++;
            if (n == 2500) chk("db_Q_mid", int'(db_Q), 2499);
        end
        chk("timeout_cycles", n, T_TIMEOUT);
        chk("to_estado", int'(db_estado), int'(seg(4'hF)));
        chk("to_Q_cleared", int'(db_Q), 0);
        wait_pronto(10);

        // restart, one correct repeat, then timeout while waiting for the new play
        push_fim(1'b0, 1'b1, 1'b1, 4'hF);
        start_game();
        exp_cmp.push_back(1'b1);
        press(4'b0001);
        chk("esc_estado",   int'(db_estado),   int'(seg(4'h7)));
        chk("esc_contagem", int'(db_contagem), int'(seg(4'h1)));
        chk("esc_rodada",   int'(db_rodada),   int'(seg(4'h0)));
        chk("esc_memoria_kept", int'(db_memoria), int'(seg(4'h2)));
        chk("esc_igual",    int'(db_enderecoIgualRodada), 0);
        wait_pronto(T_TIMEOUT + 500);

        repeat (3) @(negedge clock);
        chk("cmp_queue_left", exp_cmp.size(), 0);
        chk("end_queue_left", exp_fim.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
